aes_spi_master: RTL and testbench
=================================

AES_SPI_MASTER -- requirements
Module: aes_spi_master

Interface
REQ-001 SHALL have parameter NK, default 4: key length in 32-bit words; legal values 4, 6, 8.
REQ-002 SHALL have parameter CLK_DIV, default 50: clk cycles per SCLK half-period; minimum 1.
REQ-003 SHALL have parameter RESP_WAIT, default 0: idle SCLK periods between the last key bit and the first response bit.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request; sampled only in IDLE.
REQ-007 mode_in  in  1  0 = encrypt, 1 = decrypt; latched on accepted start.
REQ-008 msg_in  in  128  block to send; latched on accepted start.
REQ-009 key_in  in  NK*32  key to send; latched on accepted start.
REQ-010 busy  out  1  high from the cycle after the accepted start until done.
REQ-011 done  out  1  one-cycle pulse; result is valid.
REQ-012 result  out  128  received block; holds until the next accepted start.
REQ-013 sclk  out  1  serial clock; idle low.
REQ-014 cs_n  out  1  chip select, active-low; idle high.
REQ-015 mosi  out  1  serial data to the slave.
REQ-016 miso  in  1  serial data from the slave.
REQ-017 mode_out  out  1  latched mode; stable while cs_n is low.

Function
REQ-018 SHALL implement states IDLE, TX_MSG, TX_KEY, WAIT, RX, DONE.
- IDLE->TX_MSG on start; TX_MSG->TX_KEY after 128 bits; TX_KEY->WAIT (or ->RX if RESP_WAIT=0) after NK*32 bits; WAIT->RX after RESP_WAIT periods; RX->DONE after 128 bits; DONE->IDLE after one cycle.
REQ-019 Bit period SHALL be 2*CLK_DIV clk cycles: sclk low for the first CLK_DIV cycles, high for the last CLK_DIV.
REQ-020 mosi SHALL change only at bit-period start; miso SHALL be sampled on the clk edge where sclk rises.
REQ-021 Transmission order SHALL be LSB first: msg[0..127], then key[0..NK*32-1]; mosi=0 in WAIT and RX.
REQ-022 Receive SHALL shift in as result <= {miso, result[127:1]}, so the first received bit lands in result[0].
REQ-023 sclk SHALL stay low during WAIT; cs_n SHALL stay low from TX_MSG entry through the end of RX.
REQ-024 Latency from accepted start to done SHALL be exactly 1 + 2*CLK_DIV*(256 + NK*32 + RESP_WAIT) cycles.
REQ-025 In DONE: cs_n=1, sclk=0, busy=0, done=1.
REQ-026 start SHALL be ignored while busy or in DONE; start in the cycle after done SHALL be accepted.
REQ-027 Bit counter SHALL be 9 bits wide, cleared at each state entry, with no wrap.

Reset
REQ-028 Assertion SHALL force, immediately and independent of clk: state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, result=0, mode_out=0, all counters=0.
REQ-029 Reset mid-transfer SHALL abort with no done pulse; after release, the block SHALL accept start normally.

Configuration
REQ-030 Macro AES_SPI_SELFCHECK_EN SHALL add output port match (1 bit), reset 0.
- Match is updated at done: 1 if result equals the latched msg_in, else 0.
- Without the macro, the port and comparator SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Package aes_spi_pkg SHALL hold: the state enum, ENCR=1'b0, DECR=1'b1, BLOCK_W=128, and the function key_bits(NK)=NK*32.
REQ-032 A single sub-module aes_spi_clkgen SHALL produce bit-start and sample-edge ticks from CLK_DIV; it is gated by cs_n low.

Verification
REQ-033 NK=4, CLK_DIV=2, mode 0, msg 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c; slave model returns 3925841d02dc09fbdc118597196a0b32 -> result matches, done at cycle 1537 after start.
REQ-034 Same stimulus: first 8 mosi bits SHALL be 0,0,1,0,1,1,0,0 (msg byte 0x34, LSB first); mode_out=0 throughout cs_n low.
REQ-035 NK=8, CLK_DIV=1, RESP_WAIT=3, key 000102...1f -> exactly 256 key bits; sclk low for 6 cycles before RX; done at cycle 1 + 2*(256+256+3) = 1031.
REQ-036 start pulsed during TX_KEY and in the DONE cycle -> ignored; start in the cycle after done -> new transfer begins.
REQ-037 reset low at bit 40 of TX_KEY -> cs_n=1 and busy=0 without waiting for a clk edge; no done; a following transfer succeeds.
REQ-038 AES_SPI_SELFCHECK_EN, mode 1, slave echoes msg -> match=1; same with miso bit 5 flipped -> match=0 and result[5] inverted.

Source files
------------

// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI master: state encoding, mode codes,
// block width and the key-length helper.
package aes_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TX_MSG,
        TX_KEY,
        WAIT,
        RX,
        DONE
    } state_e;

    localparam logic ENCR    = 1'b0;
    localparam logic DECR    = 1'b1;
    localparam int   BLOCK_W = 128;
    localparam int   CNT_W   = 9;

    function automatic int key_bits(input int nk);
        return nk * 32;
    endfunction

endpackage

// File: rtl/aes_spi_clkgen.sv
// Bit-period timebase: 2*CLK_DIV clk cycles per bit, sclk phase plus end-of-bit
// and sclk-rise ticks; held at phase zero while en_i is low.
module aes_spi_clkgen #(
    parameter int CLK_DIV = 50
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic phase_o,
    output logic bit_end_o,
    output logic sample_o
);
    localparam int            CW     = $clog2(2 * CLK_DIV);
    localparam logic [CW-1:0] LAST   = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] HALF   = CW'(CLK_DIV);
    localparam logic [CW-1:0] SAMPLE = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!en_i || cnt_q == LAST) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign phase_o   = en_i && (cnt_q >= HALF);
    assign bit_end_o = en_i && (cnt_q == LAST);
    // The edge that ends this cycle is the one where sclk rises.
    assign sample_o  = en_i && (cnt_q == SAMPLE);

endmodule

// File: rtl/aes_spi_master.sv
// SPI master that ships a 128-bit block and an NK-word key LSB first, then reads
// a 128-bit response. Define AES_SPI_SELFCHECK_EN to add the match_o comparator.
module aes_spi_master
    import aes_spi_pkg::*;
#(
    parameter int NK        = 4,
    parameter int CLK_DIV   = 50,
    parameter int RESP_WAIT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 mode_i,
    input  logic [BLOCK_W-1:0]   msg_i,
    input  logic [NK*32-1:0]     key_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [BLOCK_W-1:0]   result_o,
    output logic                 sclk_o,
    output logic                 cs_n_o,
    output logic                 mosi_o,
    input  logic                 miso_i,
    output logic                 mode_o
`ifdef AES_SPI_SELFCHECK_EN
    ,
    output logic                 match_o
`endif
);
    localparam int               KB        = key_bits(NK);
    localparam int               TX_W      = BLOCK_W + KB;
    localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLOCK_W - 1);
    localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KB - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESP_WAIT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TX_W-1:0]     tx_q, tx_d;
    logic [BLOCK_W-1:0]  rx_q, rx_d;
    logic                mode_q, mode_d;
    logic                cs_n_q, cs_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    last_cnt;
    state_e              after_st;
    logic                phase, bit_end, sample;

    aes_spi_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_i      (~cs_n_q),
        .phase_o   (phase),
        .bit_end_o (bit_end),
        .sample_o  (sample)
    );

    // Terminal count and successor of each shifting state.
    always_comb begin
        last_cnt = BLK_LAST;
        after_st = IDLE;
        unique case (state_q)
            TX_MSG:  after_st = TX_KEY;
            TX_KEY: begin
                last_cnt = KEY_LAST;
                after_st = (RESP_WAIT > 0) ? WAIT : RX;
            end
            WAIT: begin
                last_cnt = WAIT_LAST;
                after_st = RX;
            end
            RX:      after_st = DONE;
            default: after_st = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        mode_d    = mode_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: if (start_i) begin
                state_d   = TX_MSG;
                bit_cnt_d = '0;
                tx_d      = {key_i, msg_i};
                mode_d    = mode_i ? DECR : ENCR;
                cs_n_d    = 1'b0;
                busy_d    = 1'b1;
            end
            TX_MSG, TX_KEY, WAIT, RX: begin
                if (state_q == RX && sample) rx_d = {miso_i, rx_q[BLOCK_W-1:1]};
                if (bit_end) begin
                    tx_d      = {1'b0, tx_q[TX_W-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == last_cnt) begin
                        state_d   = after_st;
                        bit_cnt_d = '0;
                        if (after_st == DONE) begin
                            cs_n_d = 1'b1;
                            busy_d = 1'b0;
                            done_d = 1'b1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; the result
    // register is reset as well because its reset value is observable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            mode_q    <= ENCR;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            mode_q    <= mode_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef AES_SPI_SELFCHECK_EN
    logic [BLOCK_W-1:0] msg_q;
    logic               match_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_q   <= '0;
            match_q <= 1'b0;
        end else begin
            if (state_q == IDLE && start_i) msg_q <= msg_i;
            if (done_d) match_q <= (rx_q == msg_q);
        end
    end

    assign match_o = match_q;
`endif

    // tx_q drains to zero, so mosi is naturally low in WAIT and RX.
    assign mosi_o   = tx_q[0];
    assign sclk_o   = phase && (state_q != WAIT);
    assign cs_n_o   = cs_n_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign mode_o   = mode_q;
    assign result_o = rx_q;

endmodule

// File: tb/tb_aes_spi_master.sv
// Self-checking bench for aes_spi_master: two configurations driven by a
// cycle-indexed slave/waveform model built from the bit-period timing rules.
module tb_aes_spi_master;
    import aes_spi_pkg::*;

    localparam int NK0 = 4, CD0 = 2, RW0 = 0;
    localparam int NK1 = 8, CD1 = 1, RW1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start[2], mode_in[2], miso[2];
    logic [127:0] msg[2];
    logic [255:0] key[2];
    logic         busy[2], done[2], sclk[2], cs_n[2], mosi[2], mode_out[2];
    logic [127:0] result[2];
`ifdef AES_SPI_SELFCHECK_EN
    logic         match[2];
`endif

    aes_spi_master #(.NK(NK0), .CLK_DIV(CD0), .RESP_WAIT(RW0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start_i(start[0]), .mode_i(mode_in[0]),
        .msg_i(msg[0]), .key_i(key[0][127:0]), .busy_o(busy[0]), .done_o(done[0]),
        .result_o(result[0]), .sclk_o(sclk[0]), .cs_n_o(cs_n[0]), .mosi_o(mosi[0]),
        .miso_i(miso[0]), .mode_o(mode_out[0])
`ifdef AES_SPI_SELFCHECK_EN
        , .match_o(match[0])
`endif
    );

    aes_spi_master #(.NK(NK1), .CLK_DIV(CD1), .RESP_WAIT(RW1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start_i(start[1]), .mode_i(mode_in[1]),
        .msg_i(msg[1]), .key_i(key[1]), .busy_o(busy[1]), .done_o(done[1]),
        .result_o(result[1]), .sclk_o(sclk[1]), .cs_n_o(cs_n[1]), .mosi_o(mosi[1]),
        .miso_i(miso[1]), .mode_o(mode_out[1])
`ifdef AES_SPI_SELFCHECK_EN
        , .match_o(match[1])
`endif
    );

    function automatic int nk_of(input int i); return (i == 0) ? NK0 : NK1; endfunction
    function automatic int cd_of(input int i); return (i == 0) ? CD0 : CD1; endfunction
    function automatic int rw_of(input int i); return (i == 0) ? RW0 : RW1; endfunction

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state: what the current transfer must look like on the wire.
    logic [127:0] exp_msg[2], exp_resp[2];
    logic [255:0] exp_key[2];
    logic         exp_mode[2];
    logic         mon_on[2];
    int           cyc[2], mon_err[2], mon_first[2];
    logic [7:0]   first8[2];

    int   m_c, m_p, m_d2, m_kb, m_n, m_cd, m_rw;
    logic e_sclk, e_cs, e_busy, e_done, e_mosi, e_miso;

    // Cycle c counts from the accepting edge; bit period p = c / (2*CLK_DIV).
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mon_on[i]) begin
                m_cd = cd_of(i); m_d2 = 2 * m_cd; m_kb = 32 * nk_of(i); m_rw = rw_of(i);
                m_n  = 256 + m_kb + m_rw;
                m_c  = cyc[i];
                m_p  = m_c / m_d2;
                e_sclk = 1'b0; e_mosi = 1'b0; e_miso = 1'b0;
                if (m_c < m_n * m_d2) begin
                    e_cs = 1'b0; e_busy = 1'b1; e_done = 1'b0;
                    if (!(m_p >= 128 + m_kb && m_p < 128 + m_kb + m_rw))
                        e_sclk = (m_c % m_d2) >= m_cd;
                    if (m_p < 128) e_mosi = exp_msg[i][m_p];
                    else if (m_p < 128 + m_kb) e_mosi = exp_key[i][m_p - 128];
                    if (m_p >= 128 + m_kb + m_rw) e_miso = exp_resp[i][m_p - (128 + m_kb + m_rw)];
                end else begin
                    e_cs = 1'b1; e_busy = 1'b0; e_done = 1'b1;
                end
                if ({sclk[i], cs_n[i], busy[i], done[i], mosi[i]} !== {e_sclk, e_cs, e_busy, e_done, e_mosi}
                    || (m_c < m_n * m_d2 && mode_out[i] !== exp_mode[i])) begin
                    if (mon_err[i] == 0) mon_first[i] = m_c;
                    mon_err[i]++;
                end
                if ((m_c % m_d2) == m_cd && m_p < 8) first8[i][m_p] = mosi[i];
                miso[i] = e_miso;
                if (m_c >= m_n * m_d2) mon_on[i] = 1'b0;
                else cyc[i]++;
            end
        end
    end

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called just after a rising edge; start is sampled on the next one.
    task automatic xfer(input int i, input logic md, input logic [127:0] m, input logic [255:0] k,
                        input logic [127:0] r, input bit glitch, input string tag);
        int n_exp, lat;
        bit got;
        n_exp = 1 + 2 * cd_of(i) * (256 + 32 * nk_of(i) + rw_of(i));
        exp_msg[i] = m; exp_key[i] = k; exp_resp[i] = r; exp_mode[i] = md;
        mon_err[i] = 0; mon_first[i] = -1; first8[i] = '0;
        mode_in[i] = md; msg[i] = m; key[i] = k; start[i] = 1'b1;
        lat = 0; got = 1'b0;
        while (!got && lat < n_exp + 50) begin
            @(posedge clk);
            lat++;
            if (lat == 1) begin cyc[i] = 0; mon_on[i] = 1'b1; end
            #1;
            start[i] = 1'b0; mode_in[i] = ~md; msg[i] = ~m; key[i] = ~k;
            if (glitch && lat == 2 * cd_of(i) * (128 + 5)) start[i] = 1'b1;
            got = done[i];
        end
        check({tag, " latency"}, 256'(lat), 256'(n_exp));
        check({tag, " result"}, result[i], r);
        if (glitch) start[i] = 1'b1;
        @(posedge clk);
        #1;
        start[i] = 1'b0;
        check({tag, " done_one_cycle"}, done[i], 1'b0);
        check({tag, " idle_after_done"}, busy[i], 1'b0);
        check({tag, " result_hold"}, result[i], r);
        check({tag, " wave_errors"}, 256'(mon_err[i]), 256'(0));
        mon_on[i] = 1'b0;
    endtask

    initial begin
        logic [127:0] m, r;
        logic [255:0] k;
        int dseen;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; mode_in[i] = 1'b0; msg[i] = '0; key[i] = '0;
            miso[i] = 1'b0; mon_on[i] = 1'b0; cyc[i] = 0; mon_err[i] = 0;
        end
        #12;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d outputs", i),
                  {sclk[i], cs_n[i], mosi[i], busy[i], done[i], mode_out[i]}, 6'b010000);
            check($sformatf("rst%0d result", i), result[i], '0);
`ifdef AES_SPI_SELFCHECK_EN
            check($sformatf("rst%0d match", i), match[i], 1'b0);
`endif
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known-answer transfer, NK=4, CLK_DIV=2.
        xfer(0, ENCR, 128'h3243f6a8885a308d313198a2e0370734,
             {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c},
             128'h3925841d02dc09fbdc118597196a0b32, 1'b0, "aes_vec");
        check("aes_vec first_byte", first8[0], 8'h34);

        // 256-bit key with a response gap, NK=8, CLK_DIV=1, RESP_WAIT=3.
        xfer(1, DECR, rnd128(), 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
             rnd128(), 1'b0, "nk8_wait");

        for (int t = 0; t < 3; t++)
            xfer(0, 1'($urandom_range(1)), rnd128(), {128'h0, rnd128()}, rnd128(), 1'b0,
                 $sformatf("rnd0_%0d", t));
        for (int t = 0; t < 2; t++)
            xfer(1, 1'($urandom_range(1)), rnd128(), {rnd128(), rnd128()}, rnd128(), 1'b0,
                 $sformatf("rnd1_%0d", t));

        // Stray starts in TX_KEY and DONE, then a start right after done.
        xfer(0, DECR, rnd128(), {128'h0, rnd128()}, rnd128(), 1'b1, "glitch");
        xfer(0, ENCR, rnd128(), {128'h0, rnd128()}, rnd128(), 1'b0, "back2back");

        // Reset during bit 40 of the key phase.
        mode_in[0] = DECR; msg[0] = rnd128(); key[0] = {128'h0, rnd128()}; start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (2 * CD0 * (128 + 40)) @(posedge clk);
        #2;
        check("pre_rst active", {cs_n[0], busy[0]}, 2'b01);
        rst_n = 1'b0;
        #1;
        check("mid_rst async", {cs_n[0], busy[0], sclk[0], mosi[0], done[0], mode_out[0]}, 6'b100000);
        check("mid_rst result", result[0], '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dseen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done[0] || busy[0]) dseen++;
        end
        check("post_rst quiet", 256'(dseen), 256'(0));
        xfer(0, ENCR, rnd128(), {128'h0, rnd128()}, rnd128(), 1'b0, "post_rst");

`ifdef AES_SPI_SELFCHECK_EN
        m = rnd128();
        k = {128'h0, rnd128()};
        xfer(0, DECR, m, k, m, 1'b0, "echo");
        check("echo match", match[0], 1'b1);
        r = m ^ (128'h1 << 5);
        xfer(0, DECR, m, k, r, 1'b0, "echo_flip");
        check("echo_flip match", match[0], 1'b0);
        check("echo_flip bit5", result[0][5], ~m[5]);
`else
        m = '0; r = '0; k = '0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
